// File: rtl/rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rf_writeback_arbiter
// Brief   : Shares the register-file write port between ALU and load writeback,
//           load-first with a bounded-wait boost for the ALU.
// Revision: 1.0
// ============================================================================
module rf_writeback_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int XLEN     = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic            RegWrite,
  output logic [4:0]      RD,
  output logic [XLEN-1:0] WriteData,
  output logic            alu_boost
);

  localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

  typedef enum logic [0:0] {
    ST_MEM_PRI = 1'b0,
    ST_BOOST   = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_wcnt;

  logic       w_alu_nz;
  logic       w_mem_nz;
  logic       w_alu_xfer;
  logic       w_alu_xfer_nz;
  logic       w_mem_xfer_nz;
  logic       w_alu_starved;
  logic [3:0] w_wcnt_inc;

  // x0 requests are acknowledged immediately and never compete for the port.
  assign w_alu_nz = alu_valid && (alu_rd != 5'd0);
  assign w_mem_nz = mem_valid && (mem_rd != 5'd0);

  assign alu_ready = !reset && alu_valid &&
                     ((alu_rd == 5'd0) || !w_mem_nz || (r_state == ST_BOOST));
  assign mem_ready = !reset && mem_valid &&
                     ((mem_rd == 5'd0) || !w_alu_nz || (r_state == ST_MEM_PRI));

  assign w_alu_xfer    = alu_valid && alu_ready;
  assign w_alu_xfer_nz = w_alu_nz && alu_ready;
  assign w_mem_xfer_nz = w_mem_nz && mem_ready;
  assign w_alu_starved = w_alu_nz && !alu_ready;
  assign w_wcnt_inc    = (r_wcnt >= c_MAX_WAIT) ? c_MAX_WAIT : (r_wcnt + 4'd1);

  assign alu_boost = (r_state == ST_BOOST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_MEM_PRI;
      r_wcnt    <= 4'd0;
      RegWrite  <= 1'b0;
      RD        <= 5'd0;
      WriteData <= '0;
    end else begin
      if (!alu_valid || w_alu_xfer_nz) begin
        r_wcnt <= 4'd0;
      end else if (w_alu_starved) begin
        r_wcnt <= w_wcnt_inc;
      end

      case (r_state)
        ST_MEM_PRI: begin
          if (w_alu_starved && (w_wcnt_inc == c_MAX_WAIT)) begin
            r_state <= ST_BOOST;
          end
        end
        ST_BOOST: begin
          if (w_alu_xfer || !alu_valid) begin
            r_state <= ST_MEM_PRI;
          end
        end
      endcase

      // At most one nonzero-rd transfer per cycle, so the branch order is moot.
      RegWrite <= w_alu_xfer_nz || w_mem_xfer_nz;
      if (w_alu_xfer_nz) begin
        RD        <= alu_rd;
        WriteData <= alu_data;
      end else if (w_mem_xfer_nz) begin
        RD        <= mem_rd;
        WriteData <= mem_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rf_writeback_arbiter
// Brief   : Vector table, corner sequence and random run against a reference
//           model for rf_writeback_arbiter.
// Revision: 1.0
// ============================================================================
module tb_rf_writeback_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int XLEN     = 64;

  logic            clk       = 1'b0;
  logic            reset     = 1'b1;
  logic            alu_valid = 1'b0;
  logic [4:0]      alu_rd    = 5'd0;
  logic [XLEN-1:0] alu_data  = '0;
  logic            mem_valid = 1'b0;
  logic [4:0]      mem_rd    = 5'd0;
  logic [XLEN-1:0] mem_data  = '0;
  logic            alu_ready;
  logic            mem_ready;
  logic            RegWrite;
  logic [4:0]      RD;
  logic [XLEN-1:0] WriteData;
  logic            alu_boost;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_writeback_arbiter #(.MAX_WAIT(MAX_WAIT), .XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .RegWrite  (RegWrite),
    .RD        (RD),
    .WriteData (WriteData),
    .alu_boost (alu_boost)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [63:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [63:0] md;
    logic        ear;
    logic        emr;
    logic        ewe;
    logic [4:0]  erd;
    logic [63:0] ewd;
    logic        eboost;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic av, input logic [4:0] ard,
                              input logic [63:0] ad, input logic mv, input logic [4:0] mrd,
                              input logic [63:0] md, input logic ear, input logic emr,
                              input logic ewe, input logic [4:0] erd, input logic [63:0] ewd,
                              input logic eboost);
    vec_t t;
    t.rst = rst; t.av = av; t.ard = ard; t.ad = ad; t.mv = mv; t.mrd = mrd; t.md = md;
    t.ear = ear; t.emr = emr; t.ewe = ewe; t.erd = erd; t.ewd = ewd; t.eboost = eboost;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hs_cyc(input logic av, input logic [4:0] ard, input logic mv,
                        input logic [4:0] mrd, input logic e_ar, input logic e_boost,
                        input string tag);
    reset     = 1'b0;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = 64'h99;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = 64'h1;
    #1;
    chk({tag, " alu_ready"}, 64'(alu_ready), 64'(e_ar));
    chk({tag, " alu_boost"}, 64'(alu_boost), 64'(e_boost));
    @(negedge clk);
  endtask

  // Reference model state: consecutive refusals of the ALU and the pending boost.
  int          starve;
  logic        exp_boost;
  logic        exp_we;
  logic [4:0]  exp_rd;
  logic [63:0] exp_wd;
  logic        ap, mp, rst_r;
  logic [4:0]  ap_rd, mp_rd;
  logic [63:0] ap_d, mp_d;
  logic        a_nz, m_nz, e_ar, e_mr;

  initial begin
    // Columns: rst av ard ad mv mrd md | alu_ready mem_ready RegWrite RD WriteData boost
    vecs.push_back(mk(0, 0, 0,  0,     1, 5, 'hAA,  0, 1, 0, 0,  0,     0));
    vecs.push_back(mk(0, 0, 0,  0,     0, 0, 0,     0, 0, 1, 5,  'hAA,  0));
    vecs.push_back(mk(0, 0, 0,  0,     0, 0, 0,     0, 0, 0, 5,  'hAA,  0));
    vecs.push_back(mk(0, 1, 3,  'h11,  1, 7, 'h22,  0, 1, 0, 5,  'hAA,  0));
    vecs.push_back(mk(0, 1, 3,  'h11,  0, 0, 0,     1, 0, 1, 7,  'h22,  0));
    vecs.push_back(mk(0, 0, 0,  0,     0, 0, 0,     0, 0, 1, 3,  'h11,  0));
    vecs.push_back(mk(0, 0, 0,  0,     0, 0, 0,     0, 0, 0, 3,  'h11,  0));
    vecs.push_back(mk(0, 1, 9,  'h99,  1, 1, 'h101, 0, 1, 0, 3,  'h11,  0));
    vecs.push_back(mk(0, 1, 9,  'h99,  1, 2, 'h102, 0, 1, 1, 1,  'h101, 0));
    vecs.push_back(mk(0, 1, 9,  'h99,  1, 3, 'h103, 0, 1, 1, 2,  'h102, 0));
    vecs.push_back(mk(0, 1, 9,  'h99,  1, 4, 'h104, 0, 1, 1, 3,  'h103, 0));
    vecs.push_back(mk(0, 1, 9,  'h99,  1, 5, 'h105, 1, 0, 1, 4,  'h104, 1));
    vecs.push_back(mk(0, 0, 0,  0,     1, 5, 'h105, 0, 1, 1, 9,  'h99,  0));
    vecs.push_back(mk(0, 0, 0,  0,     1, 6, 'h106, 0, 1, 1, 5,  'h105, 0));
    vecs.push_back(mk(0, 0, 0,  0,     0, 0, 0,     0, 0, 1, 6,  'h106, 0));
    vecs.push_back(mk(0, 0, 0,  0,     0, 0, 0,     0, 0, 0, 6,  'h106, 0));
    vecs.push_back(mk(0, 1, 4,  'h44,  1, 0, 'h77,  1, 1, 0, 6,  'h106, 0));
    vecs.push_back(mk(0, 0, 0,  0,     0, 0, 0,     0, 0, 1, 4,  'h44,  0));
    vecs.push_back(mk(0, 0, 0,  0,     0, 0, 0,     0, 0, 0, 4,  'h44,  0));
    vecs.push_back(mk(0, 1, 10, 'h2,   1, 10, 'h1,  0, 1, 0, 4,  'h44,  0));
    vecs.push_back(mk(0, 1, 10, 'h2,   0, 0, 0,     1, 0, 1, 10, 'h1,   0));
    vecs.push_back(mk(0, 0, 0,  0,     0, 0, 0,     0, 0, 1, 10, 'h2,   0));
    vecs.push_back(mk(0, 0, 0,  0,     0, 0, 0,     0, 0, 0, 10, 'h2,   0));
    vecs.push_back(mk(0, 0, 0,  0,     1, 6, 'h66,  0, 1, 0, 10, 'h2,   0));
    vecs.push_back(mk(1, 1, 11, 'hBB,  1, 8, 'h88,  0, 0, 1, 6,  'h66,  0));
    vecs.push_back(mk(0, 0, 0,  0,     0, 0, 0,     0, 0, 0, 0,  0,     0));
    vecs.push_back(mk(0, 1, 2,  'h5,   0, 0, 0,     1, 0, 0, 0,  0,     0));
    vecs.push_back(mk(0, 0, 0,  0,     0, 0, 0,     0, 0, 1, 2,  'h5,   0));
    vecs.push_back(mk(0, 0, 0,  0,     0, 0, 0,     0, 0, 0, 2,  'h5,   0));
    vecs.push_back(mk(0, 1, 9,  'h99,  1, 1, 'h1,   0, 1, 0, 2,  'h5,   0));
    vecs.push_back(mk(0, 1, 9,  'h99,  1, 1, 'h1,   0, 1, 1, 1,  'h1,   0));
    vecs.push_back(mk(0, 1, 9,  'h99,  1, 1, 'h1,   0, 1, 1, 1,  'h1,   0));
    vecs.push_back(mk(0, 1, 9,  'h99,  1, 1, 'h1,   0, 1, 1, 1,  'h1,   0));
    vecs.push_back(mk(1, 1, 9,  'h99,  1, 1, 'h1,   0, 0, 1, 1,  'h1,   1));
    vecs.push_back(mk(0, 0, 0,  0,     0, 0, 0,     0, 0, 0, 0,  0,     0));

    // Reset state, with requests presented so forced-low readies are visible.
    alu_valid = 1'b1; alu_rd = 5'd3; mem_valid = 1'b1; mem_rd = 5'd4;
    repeat (2) @(negedge clk);
    #1;
    chk("reset alu_ready", 64'(alu_ready), 64'd0);
    chk("reset mem_ready", 64'(mem_ready), 64'd0);
    chk("reset RegWrite",  64'(RegWrite),  64'd0);
    chk("reset RD",        64'(RD),        64'd0);
    chk("reset WriteData", WriteData,      64'd0);
    chk("reset alu_boost", 64'(alu_boost), 64'd0);
    @(negedge clk);

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      alu_valid = vecs[i].av;
      alu_rd    = vecs[i].ard;
      alu_data  = vecs[i].ad;
      mem_valid = vecs[i].mv;
      mem_rd    = vecs[i].mrd;
      mem_data  = vecs[i].md;
      #1;
      chk($sformatf("v%0d alu_ready", i), 64'(alu_ready), 64'(vecs[i].ear));
      chk($sformatf("v%0d mem_ready", i), 64'(mem_ready), 64'(vecs[i].emr));
      chk($sformatf("v%0d RegWrite", i),  64'(RegWrite),  64'(vecs[i].ewe));
      chk($sformatf("v%0d RD", i),        64'(RD),        64'(vecs[i].erd));
      chk($sformatf("v%0d WriteData", i), WriteData,      vecs[i].ewd);
      chk($sformatf("v%0d alu_boost", i), 64'(alu_boost), 64'(vecs[i].eboost));
      @(negedge clk);
    end

    // Dropping alu_valid restarts the wait count: 3 refusals, drop, then a full 4.
    for (int k = 0; k < 3; k++) hs_cyc(1, 9, 1, 1, 0, 0, "hs refuse_a");
    hs_cyc(0, 9, 1, 1, 0, 0, "hs drop");
    for (int k = 0; k < 4; k++) hs_cyc(1, 9, 1, 1, 0, 0, "hs refuse_b");
    hs_cyc(1, 9, 1, 1, 1, 1, "hs boost_grant");
    hs_cyc(0, 0, 0, 0, 0, 0, "hs idle");

    // Random traffic; requesters hold rd/data until accepted.
    starve = 0; exp_boost = 0; exp_we = 0; exp_rd = 0; exp_wd = 0;
    ap = 0; mp = 0; ap_rd = 0; mp_rd = 0; ap_d = 0; mp_d = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c > 0) begin
        chk($sformatf("r%0d RegWrite", c),  64'(RegWrite),  64'(exp_we));
        chk($sformatf("r%0d RD", c),        64'(RD),        64'(exp_rd));
        chk($sformatf("r%0d WriteData", c), WriteData,      exp_wd);
        chk($sformatf("r%0d alu_boost", c), 64'(alu_boost), 64'(exp_boost));
      end
      rst_r = (c == 0) || ($urandom_range(0, 99) == 0);
      if (!ap && $urandom_range(0, 9) < 6) begin
        ap = 1;
        ap_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ap_d = {$urandom, $urandom};
      end
      if (!mp && $urandom_range(0, 9) < 7) begin
        mp = 1;
        mp_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        mp_d = {$urandom, $urandom};
      end
      reset = rst_r;
      alu_valid = ap; alu_rd = ap_rd; alu_data = ap_d;
      mem_valid = mp; mem_rd = mp_rd; mem_data = mp_d;
      #1;
      a_nz = ap && (ap_rd != 0);
      m_nz = mp && (mp_rd != 0);
      e_ar = !rst_r && ap && ((ap_rd == 0) || !m_nz || exp_boost);
      e_mr = !rst_r && mp && ((mp_rd == 0) || !a_nz || !exp_boost);
      chk($sformatf("r%0d alu_ready", c), 64'(alu_ready), 64'(e_ar));
      chk($sformatf("r%0d mem_ready", c), 64'(mem_ready), 64'(e_mr));
      if (rst_r) begin
        starve = 0; exp_boost = 0; exp_we = 0; exp_rd = 0; exp_wd = 0;
      end else begin
        exp_we = (a_nz && e_ar) || (m_nz && e_mr);
        if (a_nz && e_ar) begin
          exp_rd = ap_rd; exp_wd = ap_d;
        end else if (m_nz && e_mr) begin
          exp_rd = mp_rd; exp_wd = mp_d;
        end
        if (!ap || e_ar) exp_boost = 0;
        if (!ap || (a_nz && e_ar)) begin
          starve = 0;
        end else if (a_nz && !e_ar) begin
          starve = starve + 1;
          if (starve >= MAX_WAIT) exp_boost = 1;
        end
      end
      if (e_ar) ap = 0;
      if (e_mr) mp = 0;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
